// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a handshaked ALU: grants one request,
// walks the operand/result handshake with a per-wait timeout, and returns an ack.
module alu_arbiter #(
  parameter int DBITS   = 32,
  parameter int OPBITS  = 4,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic [OPBITS-1:0] aluop0,
  input  logic [OPBITS-1:0] aluop1,
  input  logic [DBITS-1:0]  opa0,
  input  logic [DBITS-1:0]  opb0,
  input  logic [DBITS-1:0]  opa1,
  input  logic [DBITS-1:0]  opb1,
  output logic              ack0,
  output logic              ack1,
  output logic [DBITS-1:0]  result,
  output logic              err,
  output logic              busy,
  output logic [DBITS-1:0]  alu_op1,
  output logic [DBITS-1:0]  alu_op2,
  output logic [OPBITS-1:0] alu_aluop,
  output logic [2:0]        alu_csr_in,
  input  logic [2:0]        alu_csr_out,
  input  logic [DBITS-1:0]  alu_op3
);

  // state    | meaning
  // IDLE     | waiting for a request, result protected
  // WAIT_OP1 | waiting for ALU OP1 port ready
  // LOAD_OP1 | OP1 stable strobe
  // WAIT_OP2 | waiting for ALU OP2 port ready
  // LOAD_OP2 | OP2 stable strobe, drop result protect
  // COMPUTE  | waiting for ALU result valid
  // DONE     | ack pulse to the granted requester
  typedef enum logic [2:0] {
    IDLE, WAIT_OP1, LOAD_OP1, WAIT_OP2, LOAD_OP2, COMPUTE, DONE
  } state_t;

  localparam int CW = ($clog2(TIMEOUT + 1) < 8) ? 8 : $clog2(TIMEOUT + 1);

  state_t            state, state_nxt;
  logic              grant, grant_nxt;
  logic              last_grant, last_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic [DBITS-1:0]  op1_nxt, op2_nxt, result_nxt;
  logic [OPBITS-1:0] aluop_nxt;
  logic [2:0]        csr_nxt;
  logic              err_nxt, ack0_nxt, ack1_nxt, busy_nxt;
  logic              pick, tmo;

  assign tmo = (cnt == CW'(TIMEOUT - 1));

  always_comb begin
    state_nxt  = state;
    grant_nxt  = grant;
    last_nxt   = last_grant;
    cnt_nxt    = cnt;
    op1_nxt    = alu_op1;
    op2_nxt    = alu_op2;
    aluop_nxt  = alu_aluop;
    csr_nxt    = alu_csr_in;
    result_nxt = result;
    err_nxt    = err;
    pick       = 1'b0;

    case (state)
      IDLE: begin
        csr_nxt = 3'b001;
        if (req0 || req1) begin
          // on a tie the requester not served last wins
          pick      = (req0 && req1) ? ~last_grant : req1;
          grant_nxt = pick;
          op1_nxt   = pick ? opa1 : opa0;
          op2_nxt   = pick ? opb1 : opb0;
          aluop_nxt = pick ? aluop1 : aluop0;
          err_nxt   = 1'b0;
          cnt_nxt   = '0;
          state_nxt = WAIT_OP1;
        end
      end
      WAIT_OP1: begin
        if (alu_csr_out[0]) begin
          csr_nxt   = 3'b011;
          state_nxt = LOAD_OP1;
        end else if (tmo) begin
          result_nxt = '0;
          err_nxt    = 1'b1;
          csr_nxt    = 3'b001;
          state_nxt  = DONE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      LOAD_OP1: begin
        csr_nxt   = 3'b001;
        cnt_nxt   = '0;
        state_nxt = WAIT_OP2;
      end
      WAIT_OP2: begin
        if (alu_csr_out[1]) begin
          csr_nxt   = 3'b101;
          state_nxt = LOAD_OP2;
        end else if (tmo) begin
          result_nxt = '0;
          err_nxt    = 1'b1;
          csr_nxt    = 3'b001;
          state_nxt  = DONE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      LOAD_OP2: begin
        csr_nxt   = 3'b000;
        cnt_nxt   = '0;
        state_nxt = COMPUTE;
      end
      COMPUTE: begin
        if (alu_csr_out[2]) begin
          result_nxt = alu_op3;
          csr_nxt    = 3'b001;
          state_nxt  = DONE;
        end else if (tmo) begin
          result_nxt = '0;
          err_nxt    = 1'b1;
          csr_nxt    = 3'b001;
          state_nxt  = DONE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DONE: begin
        last_nxt  = grant;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // ack is registered, so it is high exactly during the DONE cycle
    ack0_nxt = (state_nxt == DONE) && !grant;
    ack1_nxt = (state_nxt == DONE) && grant;
    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= '0;
      alu_op1    <= '0;
      alu_op2    <= '0;
      alu_aluop  <= '0;
      alu_csr_in <= 3'b001;
      result     <= '0;
      err        <= 1'b0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_nxt;
      cnt        <= cnt_nxt;
      alu_op1    <= op1_nxt;
      alu_op2    <= op2_nxt;
      alu_aluop  <= aluop_nxt;
      alu_csr_in <= csr_nxt;
      result     <= result_nxt;
      err        <= err_nxt;
      ack0       <= ack0_nxt;
      ack1       <= ack1_nxt;
      busy       <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a simple handshaking ALU model
// (0 add, 1 sub, 2 and, 3 xor) whose port readiness and result delay are steerable.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1;
  logic [3:0]  aluop0, aluop1;
  logic [31:0] opa0, opb0, opa1, opb1;
  logic        ack0, ack1, err, busy;
  logic [31:0] result, alu_op1, alu_op2, alu_op3;
  logic [3:0]  alu_aluop;
  logic [2:0]  alu_csr_in, alu_csr_out;

  logic rdy1, rdy2;
  int   res_delay;
  int   comp_cnt;
  int   tests = 0;
  int   failed = 0;

  alu_arbiter dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1),
    .aluop0(aluop0), .aluop1(aluop1), .opa0(opa0), .opb0(opb0),
    .opa1(opa1), .opb1(opb1), .ack0(ack0), .ack1(ack1),
    .result(result), .err(err), .busy(busy),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_aluop(alu_aluop),
    .alu_csr_in(alu_csr_in), .alu_csr_out(alu_csr_out), .alu_op3(alu_op3)
  );

  always #5 clk = ~clk;

  // ALU model: result becomes valid res_delay cycles into the unprotected window
  always @(posedge clk)
    comp_cnt <= (busy && alu_csr_in == 3'b000) ? comp_cnt + 1 : 0;

  assign alu_csr_out = {(busy && alu_csr_in == 3'b000 && comp_cnt >= res_delay), rdy2, rdy1};

  always_comb begin
    case (alu_aluop)
      4'd0:    alu_op3 = alu_op1 + alu_op2;
      4'd1:    alu_op3 = alu_op1 - alu_op2;
      4'd2:    alu_op3 = alu_op1 & alu_op2;
      4'd3:    alu_op3 = alu_op1 ^ alu_op2;
      default: alu_op3 = 32'h0;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // mode 1: scramble requester-0 inputs after grant; mode 2: drop req0 mid-transaction
  task automatic txn(input string tag, input logic [1:0] exp_ack, input logic [31:0] exp_res,
                     input logic exp_err, input int exp_lat, input int exp_n1,
                     input int exp_n2, input int exp_nz, input int mode);
    int lat = 0, n1 = 0, n2 = 0, nz = 0, f1 = -1, f2 = -1;
    while (lat < 400) begin
      @(posedge clk); #1;
      lat++;
      if (mode == 1 && lat == 1) begin
        opa0 = 32'hdead; opb0 = 32'hbeef; aluop0 = 4'd3;
      end
      if (mode == 2 && lat == 2) req0 = 1'b0;
      if (alu_csr_in[1]) begin n1++; if (f1 < 0) f1 = lat; end
      if (alu_csr_in[2]) begin n2++; if (f2 < 0) f2 = lat; end
      if (alu_csr_in == 3'b000) nz++;
      if (ack0 || ack1) break;
    end
    check({tag, "_ack"}, 64'({ack1, ack0}), 64'(exp_ack));
    check({tag, "_result"}, 64'(result), 64'(exp_res));
    check({tag, "_err"}, 64'(err), 64'(exp_err));
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_csr_done"}, 64'(alu_csr_in), 64'd1);
    check({tag, "_op1_strobes"}, 64'(n1), 64'(exp_n1));
    check({tag, "_op2_strobes"}, 64'(n2), 64'(exp_n2));
    check({tag, "_unprotected"}, 64'(nz), 64'(exp_nz));
    if (exp_n1 == 1 && exp_n2 == 1)
      check({tag, "_strobe_order"}, 64'(f2 > f1), 64'd1);
    if (ack0) req0 = 1'b0;
    if (ack1) req1 = 1'b0;
    @(posedge clk); #1;
    check({tag, "_ack_one_cycle"}, 64'({ack1, ack0}), 64'd0);
    check({tag, "_idle_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int found;
    int extra;
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0;
    aluop0 = '0; aluop1 = '0; opa0 = '0; opb0 = '0; opa1 = '0; opb1 = '0;
    rdy1 = 1'b1; rdy2 = 1'b1; res_delay = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_csr", 64'(alu_csr_in), 64'd1);
    check("rst_ack", 64'({ack1, ack0}), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_alu_regs", 64'({alu_op1, alu_op2, alu_aluop} == '0), 64'd1);
    reset = 1'b0;
    @(posedge clk); #1;

    // 5+7 with inputs scrambled after grant
    req0 = 1'b1; aluop0 = 4'd0; opa0 = 32'd5; opb0 = 32'd7;
    txn("add", 2'b01, 32'd12, 1'b0, 6, 1, 1, 1, 1);
    check("latched_op1", 64'(alu_op1), 64'd5);
    check("latched_op2", 64'(alu_op2), 64'd7);
    check("latched_aluop", 64'(alu_aluop), 64'd0);
    @(posedge clk); #1;
    check("result_hold", 64'(result), 64'd12);

    // requester drops req mid-transaction
    req0 = 1'b1; aluop0 = 4'd1; opa0 = 32'd20; opb0 = 32'd3;
    txn("drop", 2'b01, 32'd17, 1'b0, 6, 1, 1, 1, 2);

    // result valid 20 cycles into COMPUTE
    res_delay = 20;
    req0 = 1'b1; aluop0 = 4'd2; opa0 = 32'hF0F0; opb0 = 32'h0FF0;
    txn("slow", 2'b01, 32'h00F0, 1'b0, 26, 1, 1, 21, 0);

    // OP2 port never ready: abort after TIMEOUT cycles in WAIT_OP2
    res_delay = 0; rdy2 = 1'b0;
    req1 = 1'b1; aluop1 = 4'd3; opa1 = 32'hA5; opb1 = 32'h0F;
    txn("tmo_op2", 2'b10, 32'd0, 1'b1, 258, 1, 0, 0, 0);
    @(posedge clk); #1;
    check("err_hold", 64'(err), 64'd1);
    check("tmo_csr_idle", 64'(alu_csr_in), 64'd1);
    rdy2 = 1'b1;

    // result valid one cycle too late: COMPUTE timeout
    res_delay = 255;
    req0 = 1'b1; aluop0 = 4'd0; opa0 = 32'd100; opb0 = 32'd1;
    txn("tmo_comp", 2'b01, 32'd0, 1'b1, 260, 1, 1, 255, 0);

    // result valid on the last allowed cycle: completes normally, err cleared
    res_delay = 254;
    req0 = 1'b1; aluop0 = 4'd0; opa0 = 32'd1; opb0 = 32'd2;
    txn("edge_ok", 2'b01, 32'd3, 1'b0, 260, 1, 1, 255, 0);

    // reset during COMPUTE
    res_delay = 30;
    req0 = 1'b1; aluop0 = 4'd0; opa0 = 32'd9; opb0 = 32'd9;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (busy && alu_csr_in == 3'b000) begin found = 1; break; end
    end
    check("reach_compute", 64'(found), 64'd1);
    reset = 1'b1; req0 = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_csr", 64'(alu_csr_in), 64'd1);
    check("mid_rst_ack", 64'({ack1, ack0}), 64'd0);
    check("mid_rst_result", 64'(result), 64'd0);
    reset = 1'b0;
    extra = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (ack0 || ack1 || busy) extra++;
    end
    check("mid_rst_quiet", 64'(extra), 64'd0);

    // round robin
    res_delay = 0;
    req0 = 1'b1; aluop0 = 4'd0; opa0 = 32'd1; opb0 = 32'd1;
    req1 = 1'b1; aluop1 = 4'd1; opa1 = 32'd9; opb1 = 32'd4;
    txn("tie_rst", 2'b01, 32'd2, 1'b0, 6, 1, 1, 1, 0);
    txn("held1", 2'b10, 32'd5, 1'b0, 6, 1, 1, 1, 0);
    req0 = 1'b1; aluop0 = 4'd0; opa0 = 32'd3; opb0 = 32'd3;
    txn("solo0", 2'b01, 32'd6, 1'b0, 6, 1, 1, 1, 0);
    req0 = 1'b1; aluop0 = 4'd0; opa0 = 32'd2; opb0 = 32'd2;
    req1 = 1'b1; aluop1 = 4'd3; opa1 = 32'd3; opb1 = 32'd1;
    txn("tie_rr", 2'b10, 32'd2, 1'b0, 6, 1, 1, 1, 0);
    txn("held0", 2'b01, 32'd4, 1'b0, 6, 1, 1, 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter DBITS, 32, operand/result width.
REQ-002 Parameter OPBITS, 4, ALU opcode width.
REQ-003 Parameter TIMEOUT, 255, max cycles spent in any ALU wait state before abort.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 req0, req1  in  1 each  requester n requests an ALU operation; held high until ackn.
REQ-007 aluop0, aluop1  in  OPBITS each  opcode; stable while reqn high.
REQ-008 opa0, opb0, opa1, opb1  in  DBITS each  operands; stable while reqn high.
REQ-009 ack0, ack1  out  1 each  one-cycle completion pulse for requester n.
REQ-010 result  out  DBITS  result, valid when any ack high.
REQ-011 err  out  1  high with ack when transaction timed out.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 alu_op1, alu_op2  out  DBITS each  operand registers driving the ALU.
REQ-014 alu_aluop  out  OPBITS  opcode register driving the ALU.
REQ-015 alu_csr_in  out  3  [0] result-protect, [1] OP1 stable, [2] OP2 stable.
REQ-016 alu_csr_out  in  3  [0] OP1 port ready, [1] OP2 port ready, [2] result valid.
REQ-017 alu_op3  in  DBITS  ALU result.

Function
REQ-018 States: IDLE, WAIT_OP1, LOAD_OP1, WAIT_OP2, LOAD_OP2, COMPUTE, DONE; all outputs registered.
REQ-019 IDLE: alu_csr_in=3'b001; if any req high, grant one, latch its aluop/opa/opb into alu_aluop/alu_op1/alu_op2, go WAIT_OP1.
REQ-020 Arbitration round-robin: single req wins; both high -> requester not granted last wins; after reset, requester 0 has priority.
REQ-021 WAIT_OP1: when alu_csr_out[0]=1, set alu_csr_in[1]=1, go LOAD_OP1.
REQ-022 LOAD_OP1: clear alu_csr_in[1], go WAIT_OP2 (OP1 stable strobe exactly one cycle).
REQ-023 WAIT_OP2: when alu_csr_out[1]=1, set alu_csr_in[2]=1, go LOAD_OP2.
REQ-024 LOAD_OP2: clear alu_csr_in[2], clear alu_csr_in[0], go COMPUTE.
REQ-025 COMPUTE: alu_csr_in[0]=0; when alu_csr_out[2]=1, capture alu_op3 into result, set alu_csr_in[0]=1, go DONE.
REQ-026 DONE: ackn=1 for granted requester only, err as set, record last grant, go IDLE; ack is exactly one cycle.
REQ-027 Timeout counter 8+ bits, cleared on entry to WAIT_OP1, WAIT_OP2, COMPUTE; increments each cycle in those states.
REQ-028 Counter reaching TIMEOUT with awaited alu_csr_out bit still low -> result=0, err=1, alu_csr_in=3'b001, go DONE.
REQ-029 Awaited bit high in same cycle counter reaches TIMEOUT -> normal progress, no error.
REQ-030 Minimum latency: req sampled in IDLE at cycle 0 with ALU always ready -> ack high in cycle 6.
REQ-031 Requester dropping req mid-transaction: transaction still completes, ack still pulses.
REQ-032 Requester shall deassert req the cycle after ack; req high in IDLE is a new request.
REQ-033 Operand/opcode changes on inputs after grant do not affect latched ALU registers.
REQ-034 result and err hold last values between transactions; err cleared at next grant.

Reset
REQ-035 Reset forces IDLE, alu_csr_in=3'b001, ack0=ack1=0, err=0, busy=0, result=0, ALU registers=0, timeout counter=0, priority to requester 0.
REQ-036 Reset mid-transaction aborts immediately with no ack pulse; takes priority over all transitions.

Verification
REQ-037 req0, aluop=ADD, 5+7, ALU ready immediately -> ack0 cycle 6, result=12, err=0, ack1 never high.
REQ-038 req0 and req1 same cycle, both held -> req0 served first, req1 served next, then req0 priority yields to req1 on next tie.
REQ-039 alu_csr_out[1] held low -> after TIMEOUT cycles in WAIT_OP2, ack pulse with err=1, result=0, alu_csr_in=3'b001.
REQ-040 Result valid delayed 20 cycles -> alu_csr_in[0]=0 throughout COMPUTE, ack 20 cycles later, correct result.
REQ-041 Reset asserted in COMPUTE -> next cycle IDLE, busy=0, alu_csr_in=3'b001, no ack.
REQ-042 alu_csr_in[1] and [2] each observed high exactly one cycle per transaction, in order [1] then [2].
